// File: rtl/dense_sched.sv
// dense_sched: sequences the fully connected classifier stage over a narrow
// shared MAC. A feature vector is buffered on acceptance, then every
// neuron x chunk pair is issued to the MAC. After the pipeline drains,
// done_o pulses.
//
// state | meaning
// IDLE  | ready_o high, waiting for a valid_i pulse
// RUN   | issuing one chunk per cycle, NUM_OUT*CHUNKS cycles
// DRAIN | waiting MAC_LAT cycles for the last result to leave the MAC
// DONE  | done_o high for one cycle, then back to IDLE
//
// Every output is a flop. Each output's next value is computed from the
// next state and next counters, so the outputs change on the same edge as
// the state they describe.
module dense_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUMI_ONCE  = 36,
  parameter int NUM_OUT    = 7,
  parameter int LANES      = 6,
  parameter int MAC_LAT    = 2,
  localparam int CHUNKS    = NUMI_ONCE / LANES,
  localparam int TOTAL     = NUM_OUT * CHUNKS,
  localparam int AW        = (TOTAL > 1) ? $clog2(TOTAL) : 1,
  localparam int NW        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_WIDTH*NUMI_ONCE-1:0] data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          drop_o,
  output logic [AW-1:0]                 w_addr_o,
  output logic [DATA_WIDTH*LANES-1:0]   mac_data_o,
  output logic                          mac_en_o,
  output logic                          mac_clr_o,
  output logic                          mac_last_o,
  output logic [NW-1:0]                 mac_neuron_o,
  output logic                          done_o
);

  localparam int CW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int DCW = $clog2(MAC_LAT + 1);
  localparam int BW  = DATA_WIDTH * NUMI_ONCE;
  localparam int LW  = DATA_WIDTH * LANES;

  if (NUMI_ONCE % LANES != 0) begin : g_bad_lanes
    $error("dense_sched: NUMI_ONCE must be a multiple of LANES");
  end
  if (MAC_LAT < 1) begin : g_bad_lat
    $error("dense_sched: MAC_LAT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   chunk_q, chunk_d;
  logic [NW-1:0]   neuron_q, neuron_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   data_q, data_d;
  logic            ready_q, ready_d;
  logic            drop_q, drop_d;
  logic            en_q, en_d;
  logic            clr_q, clr_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            issue;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d  = state_q;
    chunk_d  = chunk_q;
    neuron_d = neuron_q;
    drain_d  = drain_q;
    buf_d    = buf_q;
    addr_d   = addr_q;
    data_d   = '0;
    ready_d  = 1'b0;
    en_d     = 1'b0;
    clr_d    = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    issue    = 1'b0;
    drop_d   = valid_i && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          buf_d    = data_i;
          chunk_d  = '0;
          neuron_d = '0;
          state_d  = S_RUN;
          issue    = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_RUN: begin
        if (chunk_q == CW'(CHUNKS - 1)) begin
          if (neuron_q == NW'(NUM_OUT - 1)) begin
            state_d = S_DRAIN;
            drain_d = DCW'(MAC_LAT - 1);
          end else begin
            chunk_d  = '0;
            neuron_d = neuron_q + 1'b1;
            issue    = 1'b1;
          end
        end else begin
          chunk_d = chunk_q + 1'b1;
          issue   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The issue that is about to become visible uses the updated counters.
    if (issue) begin
      en_d   = 1'b1;
      addr_d = AW'(neuron_d) * AW'(CHUNKS) + AW'(chunk_d);
      clr_d  = (chunk_d == '0);
      last_d = (chunk_d == CW'(CHUNKS - 1));
      data_d = buf_d[chunk_d * LW +: LW];
    end
  end

  // State, counters, buffer and output flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      chunk_q  <= '0;
      neuron_q <= '0;
      drain_q  <= '0;
      buf_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      drop_q   <= 1'b0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      chunk_q  <= chunk_d;
      neuron_q <= neuron_d;
      drain_q  <= drain_d;
      buf_q    <= buf_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      drop_q   <= drop_d;
      en_q     <= en_d;
      clr_q    <= clr_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign ready_o      = ready_q;
  assign drop_o       = drop_q;
  assign w_addr_o     = addr_q;
  assign mac_data_o   = data_q;
  assign mac_en_o     = en_q;
  assign mac_clr_o    = clr_q;
  assign mac_last_o   = last_q;
  assign mac_neuron_o = neuron_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_dense_sched.sv
// Bench for dense_sched: a cycle-timeline model derived from the time of
// acceptance, checked every cycle, plus hand-computed literal checks.
module tb_dense_sched;

  logic         clk;
  logic         rstn;
  logic [287:0] data_i;
  logic         valid_i;
  logic         ready_o;
  logic         drop_o;
  logic [5:0]   w_addr_o;
  logic [47:0]  mac_data_o;
  logic         mac_en_o;
  logic         mac_clr_o;
  logic         mac_last_o;
  logic [2:0]   mac_neuron_o;
  logic         done_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int drops_seen = 0;
  int dones_seen = 0;

  dense_sched dut (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .drop_o(drop_o), .w_addr_o(w_addr_o),
    .mac_data_o(mac_data_o), .mac_en_o(mac_en_o), .mac_clr_o(mac_clr_o),
    .mac_last_o(mac_last_o), .mac_neuron_o(mac_neuron_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [287:0] mkvec(input logic [7:0] base);
    logic [287:0] v;
    v = '0;
    for (int j = 0; j < 36; j++) v[j*8 +: 8] = base + 8'(j / 2);
    return v;
  endfunction

  // Model: the whole sequence is a fixed timeline counted from acceptance.
  // Offset n=1..42 issues item n-1, 43..44 drain, 45 done, then idle.
  bit           m_active = 0;
  int           m_n = 0;
  logic [287:0] m_vec = '0;

  always @(posedge clk) begin
    logic         s_valid, s_rstn, exp_drop, en_e, live;
    logic [287:0] s_data;
    int           k, ch, nr;
    s_valid = valid_i;
    s_rstn  = rstn;
    s_data  = data_i;
    exp_drop = 1'b0;
    if (!s_rstn) begin
      m_active = 0;
      m_n = 0;
    end else begin
      exp_drop = s_valid && m_active;
      if (m_active) begin
        m_n++;
        if (m_n > 45) m_active = 0;
      end else if (s_valid) begin
        m_active = 1;
        m_n = 1;
        m_vec = s_data;
      end
    end
    #1;
    live = s_rstn && m_active;
    en_e = live && (m_n <= 42);
    k  = m_n - 1;
    ch = k % 6;
    nr = k / 6;
    chk("m_en", 64'(mac_en_o), 64'(en_e));
    chk("m_clr", 64'(mac_clr_o), 64'(en_e && ch == 0));
    chk("m_last", 64'(mac_last_o), 64'(en_e && ch == 5));
    chk("m_data", 64'(mac_data_o), en_e ? 64'(m_vec[ch*48 +: 48]) : 64'd0);
    chk("m_done", 64'(done_o), 64'(live && m_n == 45));
    chk("m_ready", 64'(ready_o), 64'(s_rstn && !m_active));
    chk("m_drop", 64'(drop_o), 64'(exp_drop));
    if (en_e) begin
      chk("m_addr", 64'(w_addr_o), 64'(k));
      chk("m_neuron", 64'(mac_neuron_o), 64'(nr));
    end else if (live && m_n <= 44) begin
      chk("m_addr_hold", 64'(w_addr_o), 64'd41);
    end else if (!s_rstn) begin
      chk("m_addr_rst", 64'(w_addr_o), 64'd0);
      chk("m_neuron_rst", 64'(mac_neuron_o), 64'd0);
    end
    if (drop_o) drops_seen++;
    if (done_o) dones_seen++;
  end

  // Accept one vector, optionally inject a second pulse at offset drop_off,
  // and check first chunk, issue count, completion time and drop count.
  task automatic run_vec(input logic [7:0] base, input logic [47:0] first_chunk,
                         input int drop_off, input int exp_drops);
    int acc, en_cnt, done_at, d0;
    d0 = drops_seen;
    @(negedge clk);
    data_i  = mkvec(base);
    valid_i = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    chk("first_data", 64'(mac_data_o), 64'(first_chunk));
    chk("first_addr", 64'(w_addr_o), 64'd0);
    chk("first_clr", 64'(mac_clr_o), 64'd1);
    chk("first_ready", 64'(ready_o), 64'd0);
    en_cnt  = mac_en_o ? 1 : 0;
    done_at = -1;
    for (int i = 1; i < 60; i++) begin
      @(negedge clk);
      valid_i = (i == drop_off);
      if (i == 1) data_i = ~data_i;
      if (i == drop_off) data_i = mkvec(8'h80);
      @(posedge clk); #1;
      if (mac_en_o) en_cnt++;
      if (done_o) begin
        done_at = cyc - acc + 1;
        break;
      end
    end
    chk("en_cycles", 64'(en_cnt), 64'd42);
    chk("done_cycle", 64'(done_at), 64'd45);
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done_o), 64'd0);
    chk("ready_after_done", 64'(ready_o), 64'd1);
    chk("drop_count", 64'(drops_seen - d0), 64'(exp_drops));
  endtask

  initial begin
    int d0;
    rstn    = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_en", 64'(mac_en_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_data", 64'(mac_data_o), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(ready_o), 64'd1);

    // Single vector: first chunk, full walk, completion timing.
    run_vec(8'h1C, 48'h1E1E1D1D1C1C, -1, 0);

    // Three vectors roughly 200 cycles apart.
    d0 = dones_seen;
    repeat (150) @(negedge clk);
    run_vec(8'h1C, 48'h1E1E1D1D1C1C, -1, 0);
    repeat (150) @(negedge clk);
    run_vec(8'h2C, 48'h2E2E2D2D2C2C, -1, 0);
    repeat (150) @(negedge clk);
    run_vec(8'h10, 48'h121211111010, -1, 0);
    chk("three_dones", 64'(dones_seen - d0), 64'd3);

    // Second valid pulse 10 cycles after acceptance is dropped.
    repeat (5) @(negedge clk);
    run_vec(8'h1C, 48'h1E1E1D1D1C1C, 10, 1);

    // Reset in cycle 20 of RUN aborts the vector.
    repeat (5) @(negedge clk);
    d0 = dones_seen;
    data_i  = mkvec(8'h2C);
    valid_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    chk("pre_abort_en", 64'(mac_en_o), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_en", 64'(mac_en_o), 64'd0);
    chk("abort_addr", 64'(w_addr_o), 64'd0);
    chk("abort_data", 64'(mac_data_o), 64'd0);
    chk("abort_neuron", 64'(mac_neuron_o), 64'd0);
    chk("abort_clr_last", 64'({mac_clr_o, mac_last_o}), 64'd0);
    chk("abort_ready", 64'(ready_o), 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("no_done_after_abort", 64'(dones_seen - d0), 64'd0);
    run_vec(8'h10, 48'h121211111010, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_sched.md
Name: dense_sched

Overview:
Controller that sequences the dense (fully connected) classifier stage over a narrow shared MAC datapath.
- Accepts one full feature vector of NUMI_ONCE values in a single-cycle valid pulse and buffers it.
- Walks every output neuron × input chunk, driving the weight-ROM address, the MAC lane data and the accumulate controls.
- Pulses done_o once all NUM_OUT class scores have drained from the MAC pipeline.

Parameters:
DATA_WIDTH, 8, bit width of each feature value.
NUMI_ONCE, 36, features per input vector.
NUM_OUT, 7, output neurons (classes).
LANES, 6, features issued to the MAC per cycle; NUMI_ONCE must be an exact multiple of LANES (elaboration error otherwise).
MAC_LAT, 2, MAC pipeline latency in cycles, from the last accumulate to the result being valid; must be >= 1.
Derived: CHUNKS = NUMI_ONCE/LANES (6). AW = clog2(NUM_OUT*CHUNKS) (6).

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
data_i  in  DATA_WIDTH*NUMI_ONCE  feature vector; feature j is data_i[j*DATA_WIDTH +: DATA_WIDTH].
valid_i  in  1  data_i valid; single-cycle pulse.
ready_o  out  1  block idle and able to accept a vector.
drop_o  out  1  one-cycle pulse: valid_i arrived while ready_o=0.
w_addr_o  out  AW  weight-ROM address = neuron*CHUNKS + chunk.
mac_data_o  out  DATA_WIDTH*LANES  features chunk*LANES .. chunk*LANES+LANES-1; lane 0 is in the LSBs.
mac_en_o  out  1  MAC accumulates this cycle.
mac_clr_o  out  1  first chunk of a neuron; MAC loads instead of adding.
mac_last_o  out  1  last chunk of a neuron.
mac_neuron_o  out  clog2(NUM_OUT)  index of the neuron being accumulated.
done_o  out  1  one-cycle pulse: all NUM_OUT results valid at the MAC output.

Behaviour:
- Reset (asynchronous, rstn=0):
  - State goes to IDLE; the chunk, neuron and drain counters and the vector buffer clear to 0.
  - All outputs are 0, including ready_o.
  - ready_o rises at the first rising clk edge after rstn is released.
- All outputs are registered. Nothing is combinational from inputs.
- IDLE:
  - ready_o=1.
  - valid_i=1 at edge k latches data_i into the buffer, sets chunk=0 and neuron=0, and enters RUN.
  - ready_o=0 from cycle k+1.
- RUN (exactly NUM_OUT*CHUNKS cycles; first issue cycle is k+1):
  - Each cycle: mac_en_o=1, mac_data_o = buffer chunk slice, w_addr_o = neuron*CHUNKS+chunk, mac_neuron_o = neuron.
  - mac_clr_o=1 when chunk==0; mac_last_o=1 when chunk==CHUNKS-1.
  - Chunk wraps CHUNKS-1 -> 0 and neuron increments on the wrap.
  - After issuing neuron NUM_OUT-1, chunk CHUNKS-1, the block enters DRAIN.
- DRAIN (MAC_LAT cycles):
  - mac_en_o, mac_clr_o and mac_last_o are 0; mac_data_o=0; w_addr_o holds its last value.
- DONE (1 cycle):
  - done_o=1, then return to IDLE.
  - ready_o=1 in the cycle after done_o.
- Default timing (acceptance at edge 0):
  - RUN occupies cycles 1..42.
  - DRAIN occupies cycles 43..44.
  - done_o is high in cycle 45.
  - ready_o is high again in cycle 46.
- Whenever mac_en_o=0, mac_data_o=0.
- valid_i while ready_o=0 (RUN, DRAIN or DONE):
  - The vector is discarded, the buffer is unchanged and the sequence is unaffected.
  - drop_o pulses in the following cycle.
- valid_i held high over several cycles in IDLE: only the first cycle is accepted; the remaining high cycles produce drop_o pulses.
- Buffer is written only on acceptance; it keeps its contents after DONE.
- Reset mid-RUN or mid-DRAIN: immediate return to IDLE with all outputs 0. done_o is never emitted for the aborted vector.

Test Plan:
1. Reset, then a single vector with feature j = 0x1C + j/2 -> first RUN cycle: w_addr_o=0, mac_clr_o=1, mac_data_o lanes 0..5 = 1C,1C,1D,1D,1E,1E.
2. Same vector, full sequence -> w_addr_o runs 0..41 contiguously; mac_last_o high at addresses 5,11,...,41; mac_neuron_o=6 at address 41; mac_en_o high for exactly 42 cycles.
3. Same vector, completion timing -> done_o high for exactly one cycle, 45 cycles after acceptance; ready_o=1 one cycle later.
4. Three vectors (bases 0x1C, 0x2C, 0x10) spaced 200 cycles apart -> three done_o pulses; the second run's first chunk is 2C,2C,2D,2D,2E,2E; no drop_o pulses.
5. Second valid_i pulse 10 cycles after acceptance -> drop_o pulses once; mac_data_o is unaffected; done_o still occurs at cycle 45.
6. rstn driven low in cycle 20 of RUN, then released; followed by a fresh vector -> all outputs go 0 asynchronously with no done_o; the new vector runs a full clean 42-cycle sequence from w_addr_o=0.
